// File: rtl/rmii_tx_arbiter.sv
// rmii_tx_arbiter: round-robin frame scheduler feeding one RMII TX MAC byte port from two frame FIFOs
module rmii_tx_arbiter #(
    parameter int IFG_CYCLES = 48,
    parameter int MAX_BYTES  = 1522
) (
    input  logic        REF_CLK,
    input  logic        arst_n,
    input  logic        src0_frame_rdy,
    input  logic        src0_empty,
    input  logic [7:0]  src0_dout,
    input  logic        src0_eod,
    output logic        src0_rden,
    input  logic        src1_frame_rdy,
    input  logic        src1_empty,
    input  logic [7:0]  src1_dout,
    input  logic        src1_eod,
    output logic        src1_rden,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        tx_last,
    output logic [1:0]  grant,
    output logic [15:0] frame_count_gray,
    output logic [15:0] trunc_count_gray
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] HOLD  = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;
    localparam logic [2:0] GAP   = 3'd5;

    logic [2:0]  state;
    logic        last_grant, trunc, drain_ph, armed;
    logic [10:0] byte_cnt;
    logic [7:0]  gap_cnt;
    logic [15:0] frame_cnt, trunc_cnt;
    logic        pick, sel, cur_empty, cur_eod, take, hs, at_max, rd;
    logic [7:0]  cur_dout;

    // Source selection; in IDLE the candidate is the one about to be granted, else the active grant
    always_comb begin
        pick      = (src0_frame_rdy && src1_frame_rdy) ? ~last_grant : src1_frame_rdy;
        sel       = (state == IDLE) ? pick : grant[1];
        cur_empty = sel ? src1_empty : src0_empty;
        cur_eod   = sel ? src1_eod : src0_eod;
        cur_dout  = sel ? src1_dout : src0_dout;
        hs        = tx_valid && tx_ready;
        at_max    = byte_cnt == 11'(MAX_BYTES - 1);
        take      = armed && (state == IDLE) && (src0_frame_rdy || src1_frame_rdy) && !cur_empty;
        rd        = take || (state == HOLD && hs && !tx_last && !cur_empty) ||
                    (state == WAIT && !cur_empty) || (state == DRAIN && !drain_ph && !cur_empty);
        src0_rden = rd && !sel;
        src1_rden = rd && sel;
    end

    assign frame_count_gray = frame_cnt ^ (frame_cnt >> 1);
    assign trunc_count_gray = trunc_cnt ^ (trunc_cnt >> 1);

    // Frame FSM: grant, fetch/hold each byte, drain truncated tails, then hold off for the gap
    always_ff @(posedge REF_CLK or negedge arst_n) begin
        if (!arst_n) begin
            state      <= IDLE;
            armed      <= 1'b0;
            last_grant <= 1'b1;
            grant      <= 2'b00;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            tx_last    <= 1'b0;
            trunc      <= 1'b0;
            drain_ph   <= 1'b0;
            byte_cnt   <= 11'd0;
            gap_cnt    <= 8'd0;
            frame_cnt  <= 16'd0;
            trunc_cnt  <= 16'd0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: if (take) begin
                    grant      <= pick ? 2'b10 : 2'b01;
                    last_grant <= pick;
                    byte_cnt   <= 11'd0;
                    state      <= FETCH;
                end
                FETCH: begin
                    tx_data  <= cur_dout;
                    tx_valid <= 1'b1;
                    tx_last  <= cur_eod || at_max;
                    trunc    <= at_max && !cur_eod;
                    byte_cnt <= byte_cnt + 11'd1;
                    state    <= HOLD;
                end
                HOLD: if (hs) begin
                    tx_valid <= 1'b0;
                    tx_last  <= 1'b0;
                    if (tx_last && trunc) begin
                        drain_ph <= 1'b0;
                        state    <= DRAIN;
                    end else if (tx_last) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        gap_cnt   <= 8'(IFG_CYCLES - 1);
                        grant     <= 2'b00;
                        state     <= GAP;
                    end else begin
                        state <= cur_empty ? WAIT : FETCH;
                    end
                end
                WAIT: if (!cur_empty) state <= FETCH;
                DRAIN: if (!drain_ph) begin
                    drain_ph <= !cur_empty;
                end else if (cur_eod) begin
                    trunc_cnt <= trunc_cnt + 16'd1;
                    frame_cnt <= frame_cnt + 16'd1;
                    gap_cnt   <= 8'(IFG_CYCLES - 1);
                    grant     <= 2'b00;
                    state     <= GAP;
                end else begin
                    drain_ph <= 1'b0;
                end
                GAP: if (gap_cnt == 8'd0) state <= IDLE; else gap_cnt <= gap_cnt - 8'd1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rmii_tx_arbiter.sv
// tb_rmii_tx_arbiter: scoreboard bench for the two-source RMII TX arbiter
module tb_rmii_tx_arbiter;
    localparam int IFG   = 48;
    localparam int MAXB  = 1522;
    localparam int DEPTH = 8192;

    logic        REF_CLK = 1'b0;
    logic        arst_n  = 1'b0;
    logic        src0_frame_rdy, src0_empty, src0_eod, src0_rden;
    logic        src1_frame_rdy, src1_empty, src1_eod, src1_rden;
    logic [7:0]  src0_dout, src1_dout, tx_data;
    logic        tx_ready = 1'b1;
    logic        tx_valid, tx_last;
    logic [1:0]  grant;
    logic [15:0] frame_count_gray, trunc_count_gray;

    rmii_tx_arbiter #(.IFG_CYCLES(IFG), .MAX_BYTES(MAXB)) dut (
        .REF_CLK(REF_CLK), .arst_n(arst_n),
        .src0_frame_rdy(src0_frame_rdy), .src0_empty(src0_empty), .src0_dout(src0_dout),
        .src0_eod(src0_eod), .src0_rden(src0_rden),
        .src1_frame_rdy(src1_frame_rdy), .src1_empty(src1_empty), .src1_dout(src1_dout),
        .src1_eod(src1_eod), .src1_rden(src1_rden),
        .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
        .grant(grant), .frame_count_gray(frame_count_gray), .trunc_count_gray(trunc_count_gray)
    );

    always #10 REF_CLK = ~REF_CLK;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [1:0] grant;
    } exp_t;

    exp_t exp_q[$];
    int   gaps_q[$];
    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;
    int   hs_cnt = 0;
    int   fall_cyc = -1;
    bit   ready_div = 0;
    bit   flush = 0;

    // FIFO models: bytes {eod,data}, push counters owned by the stimulus, pop counters by the read port
    logic [8:0] mem [2][DEPTH];
    logic [8:0] dout_r [2];
    int         n_push [2];
    int         n_pop [2];
    int         f_push [2];
    int         f_pop [2];
    logic       force_empty [2];

    assign src0_empty     = (n_push[0] == n_pop[0]) || force_empty[0];
    assign src1_empty     = (n_push[1] == n_pop[1]) || force_empty[1];
    assign src0_frame_rdy = f_push[0] != f_pop[0];
    assign src1_frame_rdy = f_push[1] != f_pop[1];
    assign src0_dout      = dout_r[0][7:0];
    assign src0_eod       = dout_r[0][8];
    assign src1_dout      = dout_r[1][7:0];
    assign src1_eod       = dout_r[1][8];

    always @(posedge REF_CLK) begin
        for (int s = 0; s < 2; s++) begin
            if (flush) begin
                n_pop[s] <= n_push[s];
                f_pop[s] <= f_push[s];
            end else if ((s == 0 ? src0_rden : src1_rden) && n_pop[s] != n_push[s]) begin
                dout_r[s] <= mem[s][n_pop[s] % DEPTH];
                n_pop[s]  <= n_pop[s] + 1;
                if (mem[s][n_pop[s] % DEPTH][8]) f_pop[s] <= f_pop[s] + 1;
            end
        end
    end

    always @(posedge REF_CLK) begin
        cyc++;
        #1 tx_ready = ready_div ? (cyc % 4 == 0) : 1'b1;
    end

    // Output monitor: scoreboard pops, hold stability, read-strobe rules and inter-frame gap
    exp_t       e;
    logic       prev_pend = 0, prev_last = 0, prev_rd = 0;
    logic [7:0] prev_data = 0;
    logic [1:0] prev_grant = 0;
    always @(negedge REF_CLK) begin
        if (!arst_n) begin
            prev_pend  = 0;
            prev_rd    = 0;
            prev_grant = 0;
            fall_cyc   = -1;
        end else begin
            if (prev_pend) begin
                tests++;
                if (tx_valid !== 1'b1 || tx_data !== prev_data || tx_last !== prev_last) begin
                    failed++;
                    $display("FAIL hold_stable: got valid=%b data=%h last=%b, need valid=1 data=%h last=%b",
                             tx_valid, tx_data, tx_last, prev_data, prev_last);
                end
            end
            if (tx_valid && tx_ready) begin
                hs_cnt++;
                tests++;
                if (exp_q.size() == 0) begin
                    failed++;
                    $display("FAIL extra_byte: got data=%h last=%b grant=%b, need no byte", tx_data, tx_last, grant);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data !== e.data || tx_last !== e.last || grant !== e.grant) begin
                        failed++;
                        $display("FAIL byte %0d: got data=%h last=%b grant=%b, need data=%h last=%b grant=%b",
                                 hs_cnt, tx_data, tx_last, grant, e.data, e.last, e.grant);
                    end
                end
            end
            if (src0_rden || src1_rden) begin
                tests++;
                if ((src0_rden && src1_rden) || prev_rd || (src0_rden && (src0_empty || grant == 2'b10)) ||
                    (src1_rden && (src1_empty || grant == 2'b01))) begin
                    failed++;
                    $display("FAIL rden_rule: got rden=%b%b empty=%b%b prev=%b grant=%b, need single legal pulse",
                             src1_rden, src0_rden, src1_empty, src0_empty, prev_rd, grant);
                end
            end
            if (prev_grant != 2'b00 && grant == 2'b00) fall_cyc = cyc;
            if (prev_grant == 2'b00 && grant != 2'b00 && fall_cyc >= 0) begin
                gaps_q.push_back(cyc - fall_cyc);
                tests++;
                if (cyc - fall_cyc < IFG) begin
                    failed++;
                    $display("FAIL ifg: got %0d cycles, need >= %0d", cyc - fall_cyc, IFG);
                end
            end
            prev_pend  = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_last  = tx_last;
            prev_rd    = src0_rden || src1_rden;
            prev_grant = grant;
        end
    end

    task automatic push_frame(input int s, input int len, input logic [7:0] seed);
        exp_t x;
        int   fwd;
        fwd = (len > MAXB) ? MAXB : len;
        for (int i = 0; i < len; i++) begin
            mem[s][n_push[s] % DEPTH] = {i == len - 1, 8'(seed + 8'(i))};
            n_push[s]++;
            if (i < fwd) begin
                x.data  = 8'(seed + 8'(i));
                x.last  = (i == fwd - 1);
                x.grant = s ? 2'b10 : 2'b01;
                exp_q.push_back(x);
            end
        end
        f_push[s]++;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge REF_CLK); #1;
            if (exp_q.size() == 0 && grant == 2'b00 && !tx_valid) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge REF_CLK);
        @(negedge REF_CLK); #1;
        tests++;
        if ({tx_valid, tx_last, tx_data, grant, src0_rden, src1_rden} !== 14'd0) begin
            failed++;
            $display("FAIL reset_outputs: got valid=%b last=%b data=%h grant=%b rden=%b%b, need all 0",
                     tx_valid, tx_last, tx_data, grant, src1_rden, src0_rden);
        end
        tests++;
        if (frame_count_gray !== 16'h0 || trunc_count_gray !== 16'h0) begin
            failed++;
            $display("FAIL reset_counts: got %h/%h, need 0000/0000", frame_count_gray, trunc_count_gray);
        end
        @(posedge REF_CLK); #1 arst_n = 1;
        repeat (4) @(negedge REF_CLK);
        #1;
        tests++;
        if (grant !== 2'b00 || tx_valid !== 1'b0) begin
            failed++;
            $display("FAIL idle_no_request: got grant=%b valid=%b, need 00/0", grant, tx_valid);
        end
    endtask

    task automatic test_single_frame;
        bit ok;
        push_frame(0, 64, 8'h10);
        wait_idle(2000, ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL single_timeout: got busy, need idle"); end
        tests++;
        if (frame_count_gray !== 16'h0001 || trunc_count_gray !== 16'h0000) begin
            failed++;
            $display("FAIL single_counts: got %h/%h, need 0001/0000", frame_count_gray, trunc_count_gray);
        end
    endtask

    task automatic test_truncation;
        bit ok;
        push_frame(1, MAXB, 8'h20);
        push_frame(1, 1530, 8'h30);
        push_frame(1, 5, 8'hC0);
        wait_idle(20000, ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL trunc_timeout: got busy, need idle"); end
        tests++;
        if (trunc_count_gray !== 16'h0001 || frame_count_gray !== 16'h0006) begin
            failed++;
            $display("FAIL trunc_counts: got %h/%h, need trunc 0001 frame 0006", trunc_count_gray, frame_count_gray);
        end
        tests++;
        if (n_pop[1] !== n_push[1]) begin
            failed++;
            $display("FAIL trunc_drained: got %0d bytes read, need %0d", n_pop[1], n_push[1]);
        end
    endtask

    task automatic test_round_robin;
        bit ok;
        int bad;
        gaps_q.delete();
        for (int k = 0; k < 3; k++) begin
            push_frame(0, 4 + k, 8'(8'h50 + 8'(k * 16)));
            push_frame(1, 3 + k, 8'(8'hA0 + 8'(k * 16)));
        end
        wait_idle(3000, ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL rr_timeout: got busy, need idle"); end
        bad = 0;
        foreach (gaps_q[i]) if (gaps_q[i] != IFG + 1) bad++;
        tests++;
        if (gaps_q.size() != 6 || bad != 0) begin
            failed++;
            $display("FAIL rr_gaps: got %0d grants, %0d off-gap, need 6 grants each %0d cycles apart",
                     gaps_q.size(), bad, IFG + 1);
        end
        tests++;
        if (frame_count_gray !== 16'h000F) begin
            failed++;
            $display("FAIL rr_count: got %h, need 000f", frame_count_gray);
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        ready_div = 1;
        push_frame(0, 16, 8'hE0);
        wait_idle(2000, ok);
        ready_div = 0;
        tests++;
        if (!ok) begin failed++; $display("FAIL bp_timeout: got busy, need idle"); end
        tests++;
        if (frame_count_gray !== 16'h000E) begin
            failed++;
            $display("FAIL bp_count: got %h, need 000e", frame_count_gray);
        end
    endtask

    task automatic test_underrun;
        bit ok;
        int base, hi;
        base = hs_cnt;
        push_frame(0, 40, 8'h01);
        for (int i = 0; i < 2000 && hs_cnt < base + 20; i++) @(negedge REF_CLK);
        @(posedge REF_CLK); #1 force_empty[0] = 1;
        repeat (4) @(posedge REF_CLK);
        hi = 0;
        repeat (6) begin
            @(negedge REF_CLK); #1;
            if (tx_valid) hi++;
        end
        tests++;
        if (hi != 0) begin
            failed++;
            $display("FAIL underrun_valid: got valid high %0d cycles, need 0", hi);
        end
        @(posedge REF_CLK); #1 force_empty[0] = 0;
        wait_idle(2000, ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL underrun_timeout: got busy, need idle"); end
        tests++;
        if (frame_count_gray !== 16'h000A) begin
            failed++;
            $display("FAIL underrun_count: got %h, need 000a", frame_count_gray);
        end
    endtask

    task automatic test_reset_midframe;
        bit ok;
        int base;
        base = hs_cnt;
        push_frame(0, 60, 8'h40);
        for (int i = 0; i < 2000 && hs_cnt < base + 20; i++) @(negedge REF_CLK);
        tests++;
        if (hs_cnt < base + 20) begin
            failed++;
            $display("FAIL midframe_reach: got %0d bytes, need 20", hs_cnt - base);
        end
        @(posedge REF_CLK); #1 arst_n = 0;
        @(negedge REF_CLK); #1;
        tests++;
        if ({tx_valid, tx_last, tx_data, grant, src0_rden, src1_rden} !== 14'd0) begin
            failed++;
            $display("FAIL midreset_outputs: got valid=%b last=%b data=%h grant=%b rden=%b%b, need all 0",
                     tx_valid, tx_last, tx_data, grant, src1_rden, src0_rden);
        end
        tests++;
        if (frame_count_gray !== 16'h0 || trunc_count_gray !== 16'h0) begin
            failed++;
            $display("FAIL midreset_counts: got %h/%h, need 0000/0000", frame_count_gray, trunc_count_gray);
        end
        flush = 1;
        @(posedge REF_CLK); #1 flush = 0;
        exp_q.delete();
        push_frame(0, 6, 8'hA0);
        push_frame(1, 6, 8'h90);
        @(negedge REF_CLK); #1;
        tests++;
        if (src0_rden !== 1'b0 || src1_rden !== 1'b0 || grant !== 2'b00) begin
            failed++;
            $display("FAIL reset_hold: got rden=%b%b grant=%b, need 00/00", src1_rden, src0_rden, grant);
        end
        @(posedge REF_CLK); #1 arst_n = 1;
        wait_idle(2000, ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL postreset_timeout: got busy, need idle"); end
        tests++;
        if (frame_count_gray !== 16'h0003) begin
            failed++;
            $display("FAIL postreset_count: got %h, need 0003", frame_count_gray);
        end
    endtask

    task automatic test_count_wrap;
        bit ok;
        @(posedge REF_CLK); #1 force dut.frame_cnt = 16'hFFFF;
        @(posedge REF_CLK); #1 release dut.frame_cnt;
        @(negedge REF_CLK); #1;
        tests++;
        if (frame_count_gray !== 16'h8000) begin
            failed++;
            $display("FAIL preload_gray: got %h, need 8000", frame_count_gray);
        end
        push_frame(0, 1, 8'h77);
        wait_idle(2000, ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL wrap_timeout: got busy, need idle"); end
        tests++;
        if (frame_count_gray !== 16'h0000) begin
            failed++;
            $display("FAIL wrap_gray: got %h, need 0000", frame_count_gray);
        end
    endtask

    initial begin
        force_empty[0] = 0;
        force_empty[1] = 0;
        test_reset();
        test_single_frame();
        test_truncation();
        test_round_robin();
        test_backpressure();
        test_underrun();
        test_reset_midframe();
        test_count_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
